tcm_banked_dp: RTL and testbench

- Single-clock, two-port tightly-coupled scratchpad memory, split into NUM_BANKS word-interleaved banks.
- Port 0 serves instruction fetch; port 1 serves load/store.
- Different-bank accesses proceed in parallel. Same-bank collisions are resolved by a round-robin arbiter using a req/gnt handshake.
- Read data returns with fixed latency, qualified by rvalid. The block drops into the core in place of the flat dual-port TCM.

---
 rtl/tcm_banked_dp.sv | 175 +++++++++++++++++
 tb/tb_tcm_banked_dp.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_banked_dp.sv
// Two-port tightly-coupled scratchpad memory with word-interleaved banks and round-robin bank arbitration.
// Build option TCM_OUTREG_EN adds an output register stage, giving a read latency of 2 instead of 1.
module tcm_banked_dp #(
  parameter int    DATA_WIDTH = 32,
  parameter int    N_ENTRIES  = 4096,
  parameter int    NUM_BANKS  = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          p0_req_i,
  input  logic                          p0_we_i,
  input  logic [DATA_WIDTH/8-1:0]       p0_be_i,
  input  logic [$clog2(N_ENTRIES)-1:0]  p0_addr_i,
  input  logic [DATA_WIDTH-1:0]         p0_wdata_i,
  output logic                          p0_gnt_o,
  output logic                          p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]         p0_rdata_o,
  input  logic                          p1_req_i,
  input  logic                          p1_we_i,
  input  logic [DATA_WIDTH/8-1:0]       p1_be_i,
  input  logic [$clog2(N_ENTRIES)-1:0]  p1_addr_i,
  input  logic [DATA_WIDTH-1:0]         p1_wdata_i,
  output logic                          p1_gnt_o,
  output logic                          p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]         p1_rdata_o,
  output logic [31:0]                   conflict_cnt_o
);

  localparam int BW     = DATA_WIDTH / 8;
  localparam int AW     = $clog2(N_ENTRIES);
  localparam int LOG_NB = $clog2(NUM_BANKS);
  localparam int BANK_W = (LOG_NB > 0) ? LOG_NB : 1;
  localparam int ROW_W  = (AW - LOG_NB > 0) ? AW - LOG_NB : 1;
  localparam int ROWS   = N_ENTRIES / NUM_BANKS;

  function automatic logic [BANK_W-1:0] bank_of(input logic [AW-1:0] a);
    return BANK_W'(a & AW'(NUM_BANKS - 1));
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [AW-1:0] a);
    return ROW_W'(a >> LOG_NB);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [1:0]            req, we, gnt, acc;
  logic [BW-1:0]         be    [2];
  logic [AW-1:0]         addr  [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [BANK_W-1:0]     bank  [2];
  logic [ROW_W-1:0]      row   [2];
  logic                  conflict;
  logic                  rr_q;

  assign req      = {p1_req_i, p0_req_i};
  assign we       = {p1_we_i, p0_we_i};
  assign be[0]    = p0_be_i;
  assign be[1]    = p1_be_i;
  assign addr[0]  = p0_addr_i;
  assign addr[1]  = p1_addr_i;
  assign wdata[0] = p0_wdata_i;
  assign wdata[1] = p1_wdata_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      bank[p] = bank_of(addr[p]);
      row[p]  = row_of(addr[p]);
    end
  end

  // rr_q names the preferred port; the other one loses a same-bank collision
  assign conflict = req[0] & req[1] & (bank[0] == bank[1]);
  assign gnt[0]   = req[0] & ~(conflict & rr_q);
  assign gnt[1]   = req[1] & ~(conflict & ~rr_q);
  assign acc      = gnt & {2{rstn_i}};
  assign p0_gnt_o = gnt[0];
  assign p1_gnt_o = gnt[1];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_q           <= 1'b0;
      conflict_cnt_o <= '0;
    end else if (conflict) begin
      rr_q           <= ~rr_q;
      conflict_cnt_o <= sat_inc(conflict_cnt_o);
    end
  end

  logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [ROWS];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  hit0, hit1, wr_en, rd_en;
    logic [ROW_W-1:0]      row_sel;
    logic [BW-1:0]         be_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;

    // at most one port can be accepted into a bank per cycle
    assign hit0      = acc[0] && (bank[0] == BANK_W'(b));
    assign hit1      = acc[1] && (bank[1] == BANK_W'(b));
    assign wr_en     = (hit0 & we[0]) | (hit1 & we[1]);
    assign rd_en     = (hit0 & ~we[0]) | (hit1 & ~we[1]);
    assign row_sel   = hit0 ? row[0] : row[1];
    assign be_sel    = hit0 ? be[0] : be[1];
    assign wdata_sel = hit0 ? wdata[0] : wdata[1];

    always @(posedge clk_i) begin
      if (wr_en) begin
        for (int i = 0; i < BW; i++) begin
          if (be_sel[i]) mem[row_sel][8*i +: 8] <= wdata_sel[8*i +: 8];
        end
      end
      if (rd_en) rd_q <= mem[row_sel];
    end

    assign bank_rd[b] = rd_q;
  end

  // ---- stage p1: bank read register, per-port valid and held read data
  logic [1:0]            vld_p1;
  logic [BANK_W-1:0]     rbank_p1 [2];
  logic [DATA_WIDTH-1:0] hold_p1  [2];
  logic [DATA_WIDTH-1:0] rdata_p1 [2];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_p1 <= '0;
      for (int p = 0; p < 2; p++) hold_p1[p] <= '0;
    end else begin
      vld_p1 <= acc & ~we;
      for (int p = 0; p < 2; p++) hold_p1[p] <= rdata_p1[p];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < 2; p++) rbank_p1[p] <= bank[p];
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_p1[p] = vld_p1[p] ? bank_rd[rbank_p1[p]] : hold_p1[p];
    end
  end

`ifdef TCM_OUTREG_EN
  // ---- stage p2: optional output register
  logic [1:0]            vld_p2;
  logic [DATA_WIDTH-1:0] rdata_p2 [2];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_p2 <= '0;
      for (int p = 0; p < 2; p++) rdata_p2[p] <= '0;
    end else begin
      vld_p2 <= vld_p1;
      for (int p = 0; p < 2; p++) rdata_p2[p] <= rdata_p1[p];
    end
  end

  assign p0_rvalid_o = vld_p2[0];
  assign p1_rvalid_o = vld_p2[1];
  assign p0_rdata_o  = rdata_p2[0];
  assign p1_rdata_o  = rdata_p2[1];
`else
  assign p0_rvalid_o = vld_p1[0];
  assign p1_rvalid_o = vld_p1[1];
  assign p0_rdata_o  = rdata_p1[0];
  assign p1_rdata_o  = rdata_p1[1];
`endif

endmodule

// File: tb/tb_tcm_banked_dp.sv
// Bench for tcm_banked_dp (default build, latency 1): directed scenarios plus randomized
// two-port traffic checked each cycle against a word-array reference model.
module tb_tcm_banked_dp;
  localparam int DW = 32;
  localparam int NE = 64;
  localparam int NB = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req, we;
  logic [3:0]    be   [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wd   [2];
  logic          p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
  logic [DW-1:0] p0_rdata_o, p1_rdata_o;
  logic [31:0]   conflict_cnt_o;

  tcm_banked_dp #(.DATA_WIDTH(DW), .N_ENTRIES(NE), .NUM_BANKS(NB), .INIT_FILE("")) dut (
    .clk_i(clk), .rstn_i(rst_n),
    .p0_req_i(req[0]), .p0_we_i(we[0]), .p0_be_i(be[0]), .p0_addr_i(addr[0]), .p0_wdata_i(wd[0]),
    .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(req[1]), .p1_we_i(we[1]), .p1_be_i(be[1]), .p1_addr_i(addr[1]), .p1_wdata_i(wd[1]),
    .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [DW-1:0] mem [NE];
  bit            rr;
  logic [31:0]   cnt_m;
  bit            rv_m [2];
  logic [DW-1:0] rd_m [2];
  logic [1:0]    dgnt;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input logic [3:0] b,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p] = r; we[p] = w; be[p] = b; addr[p] = a; wd[p] = d;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rvalid0"}, 32'(p0_rvalid_o), 32'(rv_m[0]));
    check({tag, "_rdata0"}, p0_rdata_o, rd_m[0]);
    check({tag, "_rvalid1"}, 32'(p1_rvalid_o), 32'(rv_m[1]));
    check({tag, "_rdata1"}, p1_rdata_o, rd_m[1]);
    check({tag, "_cnt"}, conflict_cnt_o, cnt_m);
  endtask

  // One clock: called at a negedge with inputs already driven, returns at the next negedge.
  task automatic cycle(output bit g0, output bit g1);
    bit conf;
    bit g [2];
    #1;
    if (!rst_n) rr = 0;
    conf = req[0] && req[1] && ((addr[0] % NB) == (addr[1] % NB));
    for (int p = 0; p < 2; p++) g[p] = req[p] && (!conf || int'(rr) == p);
    dgnt = {p1_gnt_o, p0_gnt_o};
    check("gnt0", 32'(p0_gnt_o), 32'(g[0]));
    check("gnt1", 32'(p1_gnt_o), 32'(g[1]));
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        rv_m[p] = g[p] && !we[p];
        if (rv_m[p]) rd_m[p] = mem[addr[p]];
      end
      for (int p = 0; p < 2; p++) begin
        if (g[p] && we[p]) begin
          for (int i = 0; i < 4; i++) if (be[p][i]) mem[addr[p]][8*i +: 8] = wd[p][8*i +: 8];
        end
      end
      if (conf) begin
        cnt_m = cnt_m + 1;
        rr = !rr;
      end
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
    @(negedge clk);
    g0 = g[0];
    g1 = g[1];
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    rr = 0; cnt_m = '0;
    rv_m[0] = 0; rv_m[1] = 0;
    rd_m[0] = '0; rd_m[1] = '0;
    check_outputs("rst");
  endtask

  task automatic idle();
    set_port(0, 0, 0, 4'h0, '0, '0);
    set_port(1, 0, 0, 4'h0, '0, '0);
  endtask

  bit g0, g1;
  bit pend [2];
  logic [5:0] seq;

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    apply_reset();
    rst_n = 1'b1;

    // preload every word through port 1
    for (int a = 0; a < NE; a++) begin
      set_port(1, 1, 1, 4'hF, AW'(a), $urandom);
      cycle(g0, g1);
    end
    idle();

    // memory survives reset; counter and arbiter restart
    apply_reset();
    cycle(g0, g1);
    rst_n = 1'b1;

    // parallel different-bank access
    set_port(0, 1, 0, 4'h0, 6'h04, '0);
    set_port(1, 1, 1, 4'hF, 6'h05, 32'hCAFE_F00D);
    cycle(g0, g1);
    check("par_gnt", 32'(dgnt), 32'h3);
    check("par_cnt", conflict_cnt_o, 32'd0);
    check("par_rvalid", 32'(p0_rvalid_o), 32'd1);
    idle();
    cycle(g0, g1);

    // write then read
    set_port(1, 1, 1, 4'hF, 6'h10, 32'hDEAD_BEEF);
    cycle(g0, g1);
    idle();
    set_port(0, 1, 0, 4'h0, 6'h10, '0);
    cycle(g0, g1);
    check("wr_rd_rvalid", 32'(p0_rvalid_o), 32'd1);
    check("wr_rd_data", p0_rdata_o, 32'hDEAD_BEEF);
    idle();
    cycle(g0, g1);

    // byte enables
    set_port(1, 1, 1, 4'hF, 6'h20, 32'h1122_3344);
    cycle(g0, g1);
    set_port(1, 1, 1, 4'b0101, 6'h20, 32'hAABB_CCDD);
    cycle(g0, g1);
    idle();
    set_port(1, 1, 0, 4'h0, 6'h20, '0);
    cycle(g0, g1);
    check("be_data", p1_rdata_o, 32'h11BB_33DD);
    idle();
    cycle(g0, g1);

    // round-robin conflicts from reset, both ports on bank 0
    apply_reset();
    rst_n = 1'b1;
    set_port(0, 1, 0, 4'h0, 6'h00, '0);
    set_port(1, 1, 0, 4'h0, 6'h08, '0);
    seq = '0;
    for (int c = 0; c < 3; c++) begin
      cycle(g0, g1);
      seq = {seq[3:0], dgnt};
    end
    check("rr_seq", 32'(seq), 32'b01_10_01);
    check("rr_cnt", conflict_cnt_o, 32'd3);
    idle();
    cycle(g0, g1);

    // reset while read data is being presented
    set_port(0, 1, 0, 4'h0, 6'h10, '0);
    cycle(g0, g1);
    idle();
    apply_reset();
    rst_n = 1'b1;
    // reset asserted before the accepting edge: the read never completes
    set_port(0, 1, 0, 4'h0, 6'h20, '0);
    apply_reset();
    cycle(g0, g1);
    idle();
    rst_n = 1'b1;
    cycle(g0, g1);
    check("rst_no_rvalid", 32'(p0_rvalid_o), 32'd0);
    set_port(0, 1, 0, 4'h0, 6'h10, '0);
    set_port(1, 1, 0, 4'h0, 6'h21, '0);
    cycle(g0, g1);
    check("rst_keep_a", p0_rdata_o, 32'hDEAD_BEEF);
    set_port(0, 1, 0, 4'h0, 6'h20, '0);
    idle();
    set_port(0, 1, 0, 4'h0, 6'h20, '0);
    cycle(g0, g1);
    check("rst_keep_b", p0_rdata_o, 32'h11BB_33DD);
    idle();

    // randomized traffic; a denied port holds its request until granted
    pend[0] = 0; pend[1] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 3) != 0) begin
            set_port(p, 1, 1'($urandom_range(0, 1)), 4'($urandom), AW'($urandom), $urandom);
            pend[p] = 1;
          end else begin
            set_port(p, 0, 0, 4'h0, AW'($urandom), $urandom);
          end
        end
      end
      cycle(g0, g1);
      if (g0) pend[0] = 0;
      if (g1) pend[1] = 0;
    end
    idle();
    cycle(g0, g1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
